// File: rtl/xv.sv
// Shared types and constants for the host register sequencer: register map,
// STATUS layout and the sequencer state encoding.
package xv;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] word_t;

  localparam logic [3:0] XM_RD_ADDR = 4'd0;
  localparam logic [3:0] XM_WR_ADDR = 4'd1;
  localparam logic [3:0] XM_DATA    = 4'd2;
  localparam logic [3:0] XM_INCR    = 4'd3;
  localparam logic [3:0] XM_STATUS  = 4'd15;

  localparam int XM_STATUS_BUSY_BIT    = 15;
  localparam int XM_STATUS_OVERRUN_BIT = 14;

  localparam word_t XM_INCR_RESET = 16'h0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_WAIT_DATA,
    ST_ACK
  } xm_seq_state_t;

  function automatic word_t xm_status(input logic busy, input logic overrun);
    word_t s;
    s = '0;
    s[XM_STATUS_BUSY_BIT]    = busy;
    s[XM_STATUS_OVERRUN_BIT] = overrun;
    return s;
  endfunction

endpackage

// File: rtl/xm_vram_port.sv
// Host-side VRAM port: holds one request until granted, then for reads
// counts RD_LAT cycles and captures the returned word into rd_buf.
module xm_vram_port
  import xv::*;
#(
  parameter int VRAM_AW = 16,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic               start_wr_i,
  input  logic [VRAM_AW-1:0] start_addr_i,
  input  word_t              start_data_i,
  output logic               gnt_o,
  output logic               rd_done_o,
  output word_t              rd_buf_o,
  output logic               vram_req_o,
  output logic               vram_wr_o,
  output logic [VRAM_AW-1:0] vram_addr_o,
  output word_t              vram_data_o,
  input  logic               vram_gnt_i,
  input  word_t              vram_data_i
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  logic               req_q, req_d;
  logic               wr_q, wr_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  word_t              data_q, data_d;
  logic               pend_q, pend_d;
  logic [1:0]         cnt_q, cnt_d;
  word_t              rd_buf_q, rd_buf_d;

  assign gnt_o     = req_q & vram_gnt_i;
  assign rd_done_o = pend_q && (cnt_q == 2'd0);

  // NOTE: every variable gets its default first so no latch is inferred.
  always_comb begin
    req_d    = req_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    rd_buf_d = rd_buf_q;
    if (start_i) begin
      req_d  = 1'b1;
      wr_d   = start_wr_i;
      addr_d = start_addr_i;
      data_d = start_data_i;
    end
    if (gnt_o) begin
      req_d = 1'b0;
      if (!wr_q) begin
        pend_d = 1'b1;
        cnt_d  = LAT_LAST;
      end
    end
    if (pend_q) begin
      if (cnt_q == 2'd0) begin
        pend_d   = 1'b0;
        rd_buf_d = vram_data_i;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= 2'd0;
      rd_buf_q <= '0;
    end else begin
      req_q    <= req_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  assign vram_req_o  = req_q;
  assign vram_wr_o   = wr_q;
  assign vram_addr_o = addr_q;
  assign vram_data_o = data_q;
  assign rd_buf_o    = rd_buf_q;

endmodule

// File: rtl/xm_reg_sequencer.sv
// Host register file and access sequencer: byte-to-word assembly, VRAM
// reads/writes through xm_vram_port, auto-increment addresses, DTACK acks.
module xm_reg_sequencer
  import xv::*;
#(
  parameter int VRAM_AW = 16,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               write_strobe_i,
  input  logic               read_strobe_i,
  input  logic [3:0]         reg_num_i,
  input  logic               bytesel_i,
  input  logic [7:0]         bytedata_i,
  output logic [7:0]         bytedata_o,
  output logic               rd_ack_o,
  output logic               wr_ack_o,
  output logic               vram_req_o,
  output logic               vram_wr_o,
  output logic [VRAM_AW-1:0] vram_addr_o,
  output logic [15:0]        vram_data_o,
  input  logic               vram_gnt_i,
  input  logic [15:0]        vram_data_i
);

  xm_seq_state_t      state_q, state_d;
  logic               ack_rd_q, ack_rd_d;
  logic [VRAM_AW-1:0] rd_addr_q, rd_addr_d;
  logic [VRAM_AW-1:0] wr_addr_q, wr_addr_d;
  word_t              incr_q, incr_d;
  word_t              scratch_q [4:14];
  word_t              scratch_d [4:14];
  byte_t              wr_hi_q, wr_hi_d;
  word_t              rd_hold_q, rd_hold_d;
  byte_t              bytedata_q, bytedata_d;
  logic               overrun_q, overrun_d;

  logic               start;
  logic               start_wr;
  logic [VRAM_AW-1:0] start_addr;
  logic               gnt;
  logic               rd_done;
  word_t              rd_buf;
  word_t              word;
  word_t              read_val;
  logic               busy;

  assign word = {wr_hi_q, bytedata_i};
  assign busy = (state_q != ST_IDLE);

  always_comb begin
    case (reg_num_i)
      XM_RD_ADDR: read_val = word_t'(rd_addr_q);
      XM_WR_ADDR: read_val = word_t'(wr_addr_q);
      XM_DATA:    read_val = rd_buf;
      XM_INCR:    read_val = incr_q;
      XM_STATUS:  read_val = xm_status(busy, overrun_q);
      default:    read_val = scratch_q[reg_num_i];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ack_rd_d   = ack_rd_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    incr_d     = incr_q;
    scratch_d  = scratch_q;
    wr_hi_d    = wr_hi_q;
    rd_hold_d  = rd_hold_q;
    bytedata_d = bytedata_q;
    overrun_d  = overrun_q;
    start      = 1'b0;
    start_wr   = 1'b0;
    start_addr = rd_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (write_strobe_i) begin
          ack_rd_d = 1'b0;
          state_d  = ST_ACK;
          if (!bytesel_i) begin
            wr_hi_d = bytedata_i;
          end else begin
            case (reg_num_i)
              XM_RD_ADDR: begin
                rd_addr_d  = word[VRAM_AW-1:0];
                start      = 1'b1;
                start_addr = word[VRAM_AW-1:0];
                state_d    = ST_WAIT_GNT;
              end
              XM_WR_ADDR: wr_addr_d = word[VRAM_AW-1:0];
              XM_DATA: begin
                start      = 1'b1;
                start_wr   = 1'b1;
                start_addr = wr_addr_q;
                state_d    = ST_WAIT_GNT;
              end
              XM_INCR:   incr_d = word;
              XM_STATUS: overrun_d = 1'b0;
              default:   scratch_d[reg_num_i] = word;
            endcase
          end
        end else if (read_strobe_i) begin
          ack_rd_d = 1'b1;
          state_d  = ST_ACK;
          if (!bytesel_i) begin
            rd_hold_d  = read_val;
            bytedata_d = read_val[15:8];
          end else begin
            bytedata_d = rd_hold_q[7:0];
            // Odd DATA reads refill rd_buf so the next even read is ready.
            if (reg_num_i == XM_DATA) begin
              start   = 1'b1;
              state_d = ST_WAIT_GNT;
            end
          end
        end
      end
      ST_WAIT_GNT: begin
        if (gnt) begin
          if (vram_wr_o) begin
            wr_addr_d = wr_addr_q + incr_q[VRAM_AW-1:0];
            state_d   = ST_ACK;
          end else begin
            rd_addr_d = rd_addr_q + incr_q[VRAM_AW-1:0];
            state_d   = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: if (rd_done) state_d = ST_ACK;
      ST_ACK:       state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Dropped strobes win over a same-cycle STATUS clear.
    if ((busy && (write_strobe_i || read_strobe_i)) || (write_strobe_i && read_strobe_i))
      overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      ack_rd_q   <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      incr_q     <= XM_INCR_RESET;
      // NOTE: the scratch words are plain flops, so they reset with the rest.
      for (int i = 4; i <= 14; i++) scratch_q[i] <= '0;
      wr_hi_q    <= '0;
      rd_hold_q  <= '0;
      bytedata_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_rd_q   <= ack_rd_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      incr_q     <= incr_d;
      scratch_q  <= scratch_d;
      wr_hi_q    <= wr_hi_d;
      rd_hold_q  <= rd_hold_d;
      bytedata_q <= bytedata_d;
      overrun_q  <= overrun_d;
    end
  end

  xm_vram_port #(
    .VRAM_AW (VRAM_AW),
    .RD_LAT  (RD_LAT)
  ) u_vram_port (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .start_i      (start),
    .start_wr_i   (start_wr),
    .start_addr_i (start_addr),
    .start_data_i (word),
    .gnt_o        (gnt),
    .rd_done_o    (rd_done),
    .rd_buf_o     (rd_buf),
    .vram_req_o   (vram_req_o),
    .vram_wr_o    (vram_wr_o),
    .vram_addr_o  (vram_addr_o),
    .vram_data_o  (vram_data_o),
    .vram_gnt_i   (vram_gnt_i),
    .vram_data_i  (vram_data_i)
  );

  assign rd_ack_o   = (state_q == ST_ACK) &&  ack_rd_q;
  assign wr_ack_o   = (state_q == ST_ACK) && !ack_rd_q;
  assign bytedata_o = bytedata_q;

endmodule
